// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared op/state encodings and the per-bit logic function
package logic_unit_pkg;
    typedef enum logic [2:0] {
        OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ANDN, OP_PASS
    } op_e;
    typedef enum logic {IDLE, FOLD} state_e;
    function automatic logic apply_op(op_e op, logic x, logic y);
        case (op)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_NAND: return ~(x & y);
            OP_NOR:  return ~(x | y);
            OP_XNOR: return ~(x ^ y);
            OP_ANDN: return x & ~y;
            default: return x;
        endcase
    endfunction
endpackage

// File: rtl/logic_unit_if.sv
// logic_unit_if: input beat stream and result stream of logic_unit
interface logic_unit_if #(parameter int WIDTH = 8, parameter int COUNT_W = 8);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [2:0]         in_op;
    logic               in_acc;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_zero;
    logic [COUNT_W-1:0] out_count;
    modport master (
        output in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_count
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_count
    );
endinterface

// File: rtl/logic_unit_bitwise_op.sv
// bitwise_op: combinational bitwise function f(x, y) selected by op
module bitwise_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] f
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign f[i] = apply_op(op, x[i], y[i]);
    end
endmodule

// File: rtl/logic_unit.sv
// logic_unit: registered bitwise logic unit with single-beat and fold modes
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    logic_unit_if.slave bus
);
    state_e             state, state_d;
    op_e                op_q, op_d, op;
    logic [WIDTH-1:0]   acc, acc_d, x, y, f, res;
    logic [COUNT_W-1:0] cnt, cnt_d, cnt_inc, res_cnt;
    logic               accept, wr;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    // one function unit serves both paths; in FOLD the accumulator is x
    assign op      = state == FOLD ? op_q : op_e'(bus.in_op);
    assign x       = state == FOLD ? acc : bus.in_a;
    assign y       = state == FOLD ? bus.in_a : bus.in_b;
    assign cnt_inc = &cnt ? cnt : cnt + 1'b1;

    bitwise_op #(.WIDTH(WIDTH)) u_op (.op(op), .x(x), .y(y), .f(f));

    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        op_d    = op_q;
        wr      = 1'b0;
        res     = f;
        res_cnt = COUNT_W'(1);
        if (accept) begin
            if (state == IDLE && !bus.in_acc) begin
                wr = 1'b1;
            end else if (state == IDLE) begin
                op_d = op_e'(bus.in_op);
                if (bus.in_last) begin
                    wr  = 1'b1;
                    res = bus.in_a;
                end else begin
                    acc_d   = bus.in_a;
                    cnt_d   = COUNT_W'(1);
                    state_d = FOLD;
                end
            end else if (bus.in_last) begin
                wr      = 1'b1;
                res_cnt = cnt_inc;
                state_d = IDLE;
            end else begin
                acc_d = f;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            op_q          <= OP_AND;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_zero  <= 1'b1;
            bus.out_count <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            op_q  <= op_d;
            if (wr) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= res;
                bus.out_zero  <= res == '0;
                bus.out_count <= res_cnt;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_logic_unit.sv
// tb_logic_unit: scoreboard bench driving a COUNT_W=8 and a COUNT_W=2 instance in lockstep
module tb_logic_unit;
    typedef struct {
        logic [7:0] d;
        int         n;
        int         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_if #(.WIDTH(8), .COUNT_W(8)) bus1 ();
    logic_unit_if #(.WIDTH(8), .COUNT_W(2)) bus2 ();

    logic_unit #(.WIDTH(8), .COUNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    logic_unit #(.WIDTH(8), .COUNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    exp_t       q1[$];
    exp_t       q2[$];
    logic [7:0] run[$];
    int         run_op;
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rdy_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] ref_op(int op, logic [7:0] x, logic [7:0] y);
        case (op)
            0: return x & y;
            1: return x | y;
            2: return x ^ y;
            3: return ~(x & y);
            4: return ~(x | y);
            5: return ~(x ^ y);
            6: return x & ~y;
            default: return x;
        endcase
    endfunction

    function automatic void push_exp(logic [7:0] d, int n);
        exp_t e;
        e.d = d;
        e.n = n;
        e.c = cyc + 1;
        q1.push_back(e);
        q2.push_back(e);
    endfunction

    // reference: a fold run is collected whole, then reduced left to right
    function automatic void model_accept(logic [7:0] a, logic [7:0] b, int op, logic acc, logic last);
        logic [7:0] r;
        if (run.size() == 0 && !acc) begin
            push_exp(ref_op(op, a, b), 1);
        end else begin
            if (run.size() == 0) run_op = op;
            run.push_back(a);
            if (last) begin
                r = run[0];
                for (int i = 1; i < run.size(); i++) r = ref_op(run_op, r, run[i]);
                push_exp(r, run.size());
                run.delete();
            end
        end
    endfunction

    task automatic drive(logic v, logic [7:0] a, logic [7:0] b, logic [2:0] op, logic acc, logic last);
        bus1.in_valid = v; bus2.in_valid = v;
        bus1.in_a = a;     bus2.in_a = a;
        bus1.in_b = b;     bus2.in_b = b;
        bus1.in_op = op;   bus2.in_op = op;
        bus1.in_acc = acc; bus2.in_acc = acc;
        bus1.in_last = last; bus2.in_last = last;
    endtask

    task automatic send(logic [7:0] a, logic [7:0] b, logic [2:0] op, logic acc, logic last);
        int w = 0;
        @(negedge clk);
        drive(1'b1, a, b, op, acc, last);
        while (!bus1.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus1.in_ready) chk("accept_timeout", 0, 1);
        else model_accept(a, b, int'(op), acc, last);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_out_valid", bus1.out_valid, 0);
        chk("rst_out_data", bus1.out_data, 0);
        chk("rst_out_zero", bus1.out_zero, 1);
        chk("rst_out_count", bus1.out_count, 0);
        chk("rst_in_ready", bus1.in_ready, 1);
        chk("rst_out_count_sat", bus2.out_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q1.delete();
        q2.delete();
        run.delete();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_valid", bus1.out_valid, 0);
    endtask

    initial begin : ready_drv
        logic r;
        forever begin
            @(posedge clk);
            #1;
            r = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode[0];
            bus1.out_ready = r;
            bus2.out_ready = r;
        end
    end

    logic       mv, mr, mz;
    logic [7:0] md;
    int         mc;
    exp_t       me;
    logic [7:0] hd[2];
    int         hc[2];
    bit         hold[2];
    bit         shown[2];

    // monitor: checks held outputs, result latency, and pops results on each transfer
    always @(negedge clk) begin
        if (!rst_n) begin
            hold  = '{1'b0, 1'b0};
            shown = '{1'b0, 1'b0};
        end else begin
            for (int k = 0; k < 2; k++) begin
                mv = k == 0 ? bus1.out_valid : bus2.out_valid;
                mr = k == 0 ? bus1.out_ready : bus2.out_ready;
                mz = k == 0 ? bus1.out_zero : bus2.out_zero;
                md = k == 0 ? bus1.out_data : bus2.out_data;
                mc = k == 0 ? int'(bus1.out_count) : int'(bus2.out_count);
                if (hold[k]) begin
                    chk("hold_data", md, hd[k]);
                    chk("hold_count", mc, hc[k]);
                end
                if (mv && !shown[k]) begin
                    if ((k == 0 ? q1.size() : q2.size()) == 0) chk("spurious_valid", 1, 0);
                    else begin
                        me = k == 0 ? q1[0] : q2[0];
                        chk("latency", cyc, me.c);
                    end
                    shown[k] = 1'b1;
                end
                if (mv && mr) begin
                    if ((k == 0 ? q1.size() : q2.size()) != 0) begin
                        me = k == 0 ? q1.pop_front() : q2.pop_front();
                        chk(k == 0 ? "data" : "data_c2", md, me.d);
                        chk(k == 0 ? "count" : "count_c2", mc, me.n < (k == 0 ? 255 : 3) ? me.n : (k == 0 ? 255 : 3));
                        chk("zero", mz, me.d == 8'h00);
                    end
                    shown[k] = 1'b0;
                end
                hold[k] = mv && !mr;
                hd[k] = md;
                hc[k] = mc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        bus1.out_ready = 1'b1;
        bus2.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_valid", bus1.out_valid, 0);

        for (int i = 0; i < 8; i++) send(8'hCC, 8'hAA, 3'(i), 1'b0, 1'b0);

        send(8'h01, 8'h5A, 3'd1, 1'b1, 1'b0);
        send(8'h02, 8'hA5, 3'd2, 1'b1, 1'b0);
        send(8'h04, 8'h33, 3'd2, 1'b0, 1'b0);
        send(8'h08, 8'hC3, 3'd0, 1'b1, 1'b1);

        rdy_mode = 0;
        @(posedge clk);
        send(8'h3C, 8'h0F, 3'd2, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", bus1.in_ready, 0);
        end
        rdy_mode = 1;
        send(8'hF0, 8'h3C, 3'd6, 1'b0, 1'b0);
        send(8'h12, 8'h34, 3'd5, 1'b0, 1'b0);

        send(8'hFF, 8'h00, 3'd0, 1'b1, 1'b0);
        send(8'hF0, 8'h00, 3'd1, 1'b1, 1'b0);
        send(8'h0F, 8'h00, 3'd1, 1'b1, 1'b0);
        send(8'hFF, 8'h00, 3'd1, 1'b1, 1'b0);
        send(8'hFF, 8'h00, 3'd1, 1'b1, 1'b0);
        send(8'hFF, 8'h00, 3'd1, 1'b1, 1'b1);

        send(8'hAA, 8'h00, 3'd1, 1'b1, 1'b0);
        send(8'h55, 8'h00, 3'd1, 1'b1, 1'b0);
        do_reset();
        send(8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0);

        rdy_mode = 2;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                len = $urandom_range(1, 8);
                for (int j = 1; j <= len; j++)
                    send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                         j == 1 ? 1'b1 : 1'($urandom_range(0, 1)), 1'(j == len));
            end
        end

        rdy_mode = 1;
        repeat (10) @(negedge clk);
        chk("drained", q1.size() + q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
